// File: rtl/tdm_capture_ctrl_if.sv
// Word stream from the capture controller to its consumer.
interface tdm_capture_ctrl_if;
    logic        outValid;
    logic        outReady;
    logic [31:0] outData;
    logic [2:0]  outCh;
    logic        outLast;

    modport master (output outValid, output outData, output outCh, output outLast, input outReady);
    modport slave  (input outValid, input outData, input outCh, input outLast, output outReady);
endinterface

// File: rtl/tdm_capture_ctrl.sv
// TDM capture controller: deserializer enable/resync FSM, 2-slot frame FIFO, per-channel word emitter.
// Optional statistics counters are built when TDM_CAPTURE_STATS_EN is defined.
module tdm_capture_ctrl #(
    parameter int TIMEOUT    = 4096,
    parameter int RESYNC_CYC = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   stop,
    input  logic [7:0]             chMask,
    output logic                   desEnable,
    input  logic                   desValid,
    input  logic [255:0]           desData,
    tdm_capture_ctrl_if.master     out_if,
    output logic                   busy,
    output logic                   overrun,
    output logic                   resync,
    output logic [15:0]            frameCnt,
    output logic [15:0]            dropCnt
);
    localparam int MAXC = (TIMEOUT > RESYNC_CYC) ? TIMEOUT : RESYNC_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] RSY_LAST = CW'(RESYNC_CYC - 1);

    typedef enum logic [1:0] {IDLE, ARM, RUN, RESYNC} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   tmr_q, tmr_d;
    logic            resync_q, resync_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            tmr_q    <= '0;
            resync_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            resync_q <= resync_d;
        end
    end

    // One timer serves both the valid-timeout in ARM/RUN and the hold-off in RESYNC.
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        resync_d = 1'b0;
        if (stop) begin
            state_d = IDLE;
            tmr_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_d = ARM;
                    tmr_d   = '0;
                end
                ARM: begin
                    if (desValid) begin
                        state_d = RUN;
                        tmr_d   = '0;
                    end else if (tmr_q == TMO_LAST) tmr_d = '0;
                    else tmr_d = tmr_q + 1'b1;
                end
                RUN: begin
                    if (desValid) tmr_d = '0;
                    else if (tmr_q == TMO_LAST) begin
                        state_d  = RESYNC;
                        tmr_d    = '0;
                        resync_d = 1'b1;
                    end else tmr_d = tmr_q + 1'b1;
                end
                RESYNC: begin
                    if (tmr_q == RSY_LAST) begin
                        state_d = ARM;
                        tmr_d   = '0;
                    end else tmr_d = tmr_q + 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign desEnable = (state_q == ARM) || (state_q == RUN);
    assign busy      = (state_q != IDLE);
    assign resync    = resync_q;

    logic [255:0] mem_q [2];
    logic         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d, pops;
    logic         out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [31:0]  out_data_q, out_data_d;
    logic [2:0]   out_ch_q, out_ch_d;
    logic [7:0]   rem_q, rem_d;
    logic         overrun_q;

    logic         hs, fin, can_load, src_in_fifo, src_idx, load_fifo, fifo_zero_pop;
    logic         des_try, accept, drop, bypass, push, load;
    logic [255:0] sel_frame;
    logic [7:0]   sel_mask, sel_rem;
    logic [2:0]   sel_idx;
    logic         sel_last, found;
    logic [31:0]  sel_data;
    logic [31:0]  ch_word [8];

    // While a word is out, the FIFO head is the frame being emitted; the next frame sits behind it.
    always_comb begin
        hs            = out_valid_q && out_if.outReady;
        fin           = hs && out_last_q;
        can_load      = !out_valid_q || fin;
        src_in_fifo   = out_valid_q ? (count_q == 2'd2) : (count_q != 2'd0);
        src_idx       = out_valid_q ? ~rd_ptr_q : rd_ptr_q;
        load_fifo     = can_load && src_in_fifo;
        fifo_zero_pop = load_fifo && (chMask == 8'h00);
        pops          = {1'b0, fin} + {1'b0, fifo_zero_pop};
        des_try       = desValid && desEnable && !stop;
        accept        = des_try && ((count_q != 2'd2) || (pops != 2'd0));
        drop          = des_try && !accept;
        bypass        = can_load && !src_in_fifo && accept;
        push          = accept && !(bypass && (chMask == 8'h00));
        load          = load_fifo || bypass;
        sel_frame     = load ? (src_in_fifo ? mem_q[src_idx] : desData) : mem_q[rd_ptr_q];
        sel_mask      = load ? chMask : rem_q;
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_ch
        assign ch_word[gi] = sel_frame[255 - 32*gi -: 32];
    end

    always_comb begin
        sel_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (sel_mask[i] && !found) begin
                sel_idx = 3'(i);
                found   = 1'b1;
            end
        end
        sel_rem  = sel_mask & (8'hFE << sel_idx);
        sel_last = (sel_rem == 8'h00);
        sel_data = ch_word[sel_idx];
    end

    always_comb begin
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rem_d       = rem_q;
        if (stop) begin
            count_d     = '0;
            rd_ptr_d    = 1'b0;
            wr_ptr_d    = 1'b0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            rem_d       = '0;
        end else begin
            count_d  = count_q + {1'b0, push} - pops;
            rd_ptr_d = rd_ptr_q ^ pops[0];
            wr_ptr_d = wr_ptr_q ^ push;
            if (load) begin
                out_valid_d = (chMask != 8'h00);
                out_last_d  = (chMask != 8'h00) && sel_last;
                out_data_d  = sel_data;
                out_ch_d    = sel_idx;
                rem_d       = sel_rem;
            end else if (fin) begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end else if (hs) begin
                out_last_d  = sel_last;
                out_data_d  = sel_data;
                out_ch_d    = sel_idx;
                rem_d       = sel_rem;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= desData;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q     <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rem_q       <= '0;
            overrun_q   <= 1'b0;
        end else begin
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rem_q       <= rem_d;
            overrun_q   <= drop;
        end
    end

    assign out_if.outValid = out_valid_q;
    assign out_if.outData  = out_data_q;
    assign out_if.outCh    = out_ch_q;
    assign out_if.outLast  = out_last_q;
    assign overrun         = overrun_q;

`ifdef TDM_CAPTURE_STATS_EN
    logic [15:0] frame_cnt_q, drop_cnt_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (accept && (frame_cnt_q != 16'hFFFF)) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end
    assign frameCnt = frame_cnt_q;
    assign dropCnt  = drop_cnt_q;
`else
    assign frameCnt = '0;
    assign dropCnt  = '0;
`endif
endmodule

// File: doc/tdm_capture_ctrl.md
TDM_CAPTURE_CTRL -- requirements
Module: tdm_capture_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 4096: clk cycles without a deserializer valid before a resync.
REQ-002 SHALL have parameter RESYNC_CYC, default 16: clk cycles the deserializer enable is held low during a resync.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  single-cycle request to begin capture.
REQ-006 SHALL have port stop  input  1  single-cycle request to end capture and flush.
REQ-007 SHALL have port chMask  input  8  channel enable, bit i = CHi+1.
REQ-008 SHALL have port desEnable  output  1  enable to the TDM deserializer.
REQ-009 SHALL have port desValid  input  1  single-cycle frame-valid from the deserializer.
REQ-010 SHALL have port desData  input  256  frame; CH1 = [255:224] ... CH8 = [31:0].
REQ-011 SHALL have ports outValid output 1, outReady input 1, outData output 32, outCh output 3 (0 = CH1), outLast output 1: word stream to the consumer.
REQ-012 SHALL have ports busy output 1 (state != IDLE), overrun output 1 (one-cycle drop pulse), resync output 1 (one-cycle pulse), frameCnt output 16, dropCnt output 16.

Function
REQ-013 SHALL implement FSM IDLE, ARM, RUN, RESYNC; desEnable=1 only in ARM and RUN.
REQ-014 IDLE: start -> ARM next cycle; start in any other state ignored.
REQ-015 ARM: first desValid -> RUN, frame captured; TIMEOUT expiry in ARM stays ARM, counter restarts, no resync.
REQ-016 RUN: timeout counter clears on every desValid; reaching TIMEOUT-1 without desValid -> RESYNC, resync pulses.
REQ-017 RESYNC: desEnable low exactly RESYNC_CYC cycles, then ARM; desValid ignored in RESYNC.
REQ-018 stop in any state -> IDLE next cycle, both buffer slots and the in-flight output word discarded, outValid low next cycle; stop wins over simultaneous start.
REQ-019 SHALL hold a 2-slot frame FIFO; desValid accepted in ARM/RUN when not full.
REQ-020 desValid with FIFO full -> frame dropped, overrun pulses the next cycle; if a slot frees in the same cycle, frame accepted, no overrun.
REQ-021 Emitter pops the head frame, samples chMask at pop, emits enabled channels ascending CH1..CH8, one word per outValid&&outReady.
REQ-022 outValid, outData, outCh, outLast stable while outValid && !outReady.
REQ-023 outLast=1 on the highest enabled channel of a frame only.
REQ-024 chMask==0 at pop: frame consumed in 1 cycle, no output words.
REQ-025 Latency: desValid at cycle N with FIFO empty and emitter idle -> outValid at N+1; back-to-back words when outReady held high.
REQ-026 Next frame's first word follows the prior outLast handshake with zero bubble cycles.

Reset
REQ-027 On rstn low: state IDLE, desEnable=0, outValid=0, outData=0, outCh=0, outLast=0, busy=0, overrun=0, resync=0, frameCnt=0, dropCnt=0, FIFO empty, counters cleared.
REQ-028 Reset asserted mid-frame or mid-handshake SHALL abandon all state; no word emitted after release until a new start.

Configuration
REQ-029 Macro TDM_CAPTURE_STATS_EN defined: frameCnt counts accepted frames, dropCnt counts overruns, both saturate at 16'hFFFF, cleared by reset only (not by stop).
REQ-030 Macro undefined: frameCnt and dropCnt SHALL be constant 0, no counter logic; all other behaviour identical.

Verification
REQ-031 start, desValid every 300 cycles, chMask=8'hFF, outReady=1 -> 8 words/frame, outCh 0..7, outLast on outCh=7, data matches desData slices.
REQ-032 chMask=8'h81, outReady held 0 for 20 cycles -> outCh=0 word held stable, then outCh=7 with outLast=1; 3 frames queued -> third frame dropped, overrun=1 once, dropCnt=1 (STATS_EN).
REQ-033 RUN with no desValid for 4096 cycles -> resync pulse, desEnable low exactly 16 cycles, then ARM with desEnable=1.
REQ-034 stop asserted mid-frame with outValid=1 -> outValid=0 and desEnable=0 next cycle, busy=0, FIFO empty; start+stop same cycle in IDLE -> stays IDLE.
REQ-035 chMask=8'h00 frames -> no outValid ever, frameCnt increments per frame (STATS_EN), 0 without macro.
